router_out_fifo: RTL and testbench
==================================

// Module: router_out_fifo
// PURPOSE
//  Per-destination output buffer of the 1x3 router; three instances sit downstream of the sync block.
//  - Write side: takes packet bytes from the FSM datapath, qualified by the sync block's write_enb[n].
//  - Read side: drained by the external receiver via read_enb_n.
//  - Status: returns full/empty to the sync block, which builds fifo_full, vld_out and its timeout.
//  - Flush: soft_reset from the sync block's 30-cycle read timeout clears the buffer.
//  - Tags each stored byte with a header marker so data_out idles to 0 between packets.
// PARAMETERS
//  DATA_W   8    byte width; header byte = {payload_len[7:2], dest_addr[1:0]}
//  DEPTH    16   storage entries; power of two
//  ADDR_W   4    log2(DEPTH); pointers are ADDR_W+1 bits
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       synchronous, active-low
//  soft_reset  in   1       synchronous active-high flush from the sync block
//  write_enb   in   1       write strobe (one bit of the sync block's write_enb)
//  read_enb    in   1       read strobe from the receiver
//  lfd_state   in   1       1 = data_in is the packet header byte
//  data_in     in   DATA_W  byte to store
//  data_out    out  DATA_W  registered read data
//  full        out  1       DEPTH entries stored
//  empty       out  1       0 entries stored
// BEHAVIOUR
//  - Storage: DEPTH x (DATA_W+1) words; word = {lfd_state, data_in}; bit DATA_W = header tag.
//  - Pointers: wr_ptr, rd_ptr, each ADDR_W+1 bits; low ADDR_W bits index; wrap DEPTH-1 -> 0 with MSB toggle.
//  - Status flags (combinational from pointers):
//    - empty = (wr_ptr == rd_ptr)
//    - full  = (MSBs differ) && (low bits equal)
//  - Priority per edge: reset > soft_reset > read/write.
//  - reset=0:
//    - wr_ptr, rd_ptr, pkt_cnt, data_out <= 0; all storage words <= 0.
//    - Flags after the edge: full=0, empty=1.
//  - soft_reset=1:
//    - wr_ptr, rd_ptr, pkt_cnt, data_out <= 0; storage untouched.
//    - A write or read in the same cycle is discarded.
//  - Write: accepted iff write_enb && !full (flag before the edge) -> store word at wr_ptr, wr_ptr+1. Write while full is dropped silently.
//  - Read: accepted iff read_enb && !empty -> data_out <= stored byte; rd_ptr+1.
//    - data_out is valid the cycle after read_enb (1-cycle latency).
//  - Simultaneous read+write:
//    - Each direction is qualified independently on pre-edge flags.
//    - When empty: only the write occurs. When full: only the read occurs; occupancy becomes DEPTH-1.
//  - Packet counter pkt_cnt (7 bits):
//    - On an accepted read of a header-tagged word: pkt_cnt <= data[7:2] + 1 (payload + parity byte).
//    - On an accepted read of a non-header word with pkt_cnt != 0: pkt_cnt - 1.
//    - A header with payload_len = 0 loads 1 (parity only).
//  - Idle output: in a cycle with no accepted read and pkt_cnt == 0, data_out <= 0. Otherwise data_out holds.
//  - Reset or soft_reset mid-packet: counter and output cleared; the next byte read is treated per its own tag.
// TESTING
//  - Reset: reset=0 for 2 clocks -> empty=1, full=0, data_out=0x00.
//  - Packet: write 0x0C(lfd=1),0xA1,0xA2,0xA3,0x5E; read 5 back-to-back
//    -> data_out 0x0C,A1,A2,A3,5E, each 1 cycle after its read; next idle cycle data_out=0x00; empty=1.
//  - Fill: 16 writes -> full=1 after the 16th; 17th write (0xFF) dropped; 16 reads return the original order; empty=1.
//  - Full + simultaneous rd/wr: full, read_enb=write_enb=1 -> entry 0 read, write dropped, full=0, 15 entries.
//  - Wrap: 12 writes + 12 reads, then 10 writes + 10 reads -> data matches across index 15->0; empty=1 at end.
//  - Soft reset: 3 bytes stored, one read, soft_reset=1 -> next cycle empty=1, data_out=0x00, pkt_cnt=0; empty read is ignored.

Source files
------------

// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router: a DEPTH-entry byte FIFO whose words carry
// a header tag so the read side can track packet length and idle data_out to 0 between packets.
module router_out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = DATA_W - 1;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   mem_d [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W:0]   rd_word;

    // Handshake: a strobe is a request; write is taken only when !full and read only when !empty,
    // both judged on the flags before the edge. Refused strobes are dropped, never retried.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_ok   = write_enb && !full;
    assign rd_ok   = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;

        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else if (soft_reset) begin
            // Flush discards contents by pointer reset only; stale words become unreachable.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q[ADDR_W-1:0]] = {lfd_state, data_in};
                wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
            end
            if (rd_ok) begin
                data_out_d = rd_word[DATA_W-1:0];
                rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(1);
                // Header loads payload length plus one for the trailing parity byte.
                if (rd_word[DATA_W])
                    pkt_cnt_d = {1'b0, rd_word[DATA_W-1:2]} + CNT_W'(1);
                else if (pkt_cnt_q != '0)
                    pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
            end else if (pkt_cnt_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q      <= mem_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        pkt_cnt_q  <= pkt_cnt_d;
        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_router_out_fifo.sv
// Bench for router_out_fifo: constant vector table, hand-written corner sequences and a random
// run, all checked every cycle against a queue-based reference model.
module tb_router_out_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue of {tag, byte}, plus expected output and packet count.
  logic [8:0] mq[$];
  logic [7:0] m_dout;
  int         m_cnt;

  router_out_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[29];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic sr, input logic we, input logic re,
                            input logic lfd, input logic [7:0] din);
    bit         wr_ok;
    bit         rd_ok;
    logic [8:0] w;
    if (!rst_n || sr) begin
      mq.delete();
      m_dout = 8'h00;
      m_cnt  = 0;
    end else begin
      wr_ok = we && (mq.size() < DEPTH);
      rd_ok = re && (mq.size() != 0);
      if (rd_ok) begin
        w = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = int'(w[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
  endtask

  task automatic step(input logic rst_n, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din);
    reset      = rst_n;
    soft_reset = sr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clock);
    model_edge(rst_n, sr, we, re, lfd, din);
    #1;
    check("model_dout", 32'(data_out), 32'(m_dout));
    check("model_full", 32'(full), 32'(mq.size() == DEPTH));
    check("model_empty", 32'(empty), 32'(mq.size() == 0));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_dout", 32'(data_out), 32'h00);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] din);
    step(1'b1, 1'b0, 1'b1, 1'b0, lfd, din);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    // Packet, mid-packet hold, zero-length header and empty simultaneous rd/wr.
    vecs[0]  = '{1, 0, 1, 8'h0C, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'hA1, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'hA2, 8'h00, 0, 0};
    vecs[3]  = '{1, 0, 0, 8'hA3, 8'h00, 0, 0};
    vecs[4]  = '{1, 0, 0, 8'h5E, 8'h00, 0, 0};
    vecs[5]  = '{0, 1, 0, 8'h00, 8'h0C, 0, 0};
    vecs[6]  = '{0, 1, 0, 8'h00, 8'hA1, 0, 0};
    vecs[7]  = '{0, 1, 0, 8'h00, 8'hA2, 0, 0};
    vecs[8]  = '{0, 1, 0, 8'h00, 8'hA3, 0, 0};
    vecs[9]  = '{0, 1, 0, 8'h00, 8'h5E, 0, 1};
    vecs[10] = '{0, 0, 0, 8'h00, 8'h00, 0, 1};
    vecs[11] = '{1, 0, 1, 8'h04, 8'h00, 0, 0};
    vecs[12] = '{1, 0, 0, 8'h77, 8'h00, 0, 0};
    vecs[13] = '{1, 0, 0, 8'h99, 8'h00, 0, 0};
    vecs[14] = '{0, 1, 0, 8'h00, 8'h04, 0, 0};
    vecs[15] = '{0, 0, 0, 8'h00, 8'h04, 0, 0};
    vecs[16] = '{0, 1, 0, 8'h00, 8'h77, 0, 0};
    vecs[17] = '{0, 0, 0, 8'h00, 8'h77, 0, 0};
    vecs[18] = '{0, 1, 0, 8'h00, 8'h99, 0, 1};
    vecs[19] = '{0, 0, 0, 8'h00, 8'h00, 0, 1};
    vecs[20] = '{1, 0, 1, 8'h01, 8'h00, 0, 0};
    vecs[21] = '{1, 0, 0, 8'h33, 8'h00, 0, 0};
    vecs[22] = '{0, 1, 0, 8'h00, 8'h01, 0, 0};
    vecs[23] = '{0, 0, 0, 8'h00, 8'h01, 0, 0};
    vecs[24] = '{0, 1, 0, 8'h00, 8'h33, 0, 1};
    vecs[25] = '{0, 0, 0, 8'h00, 8'h00, 0, 1};
    vecs[26] = '{1, 1, 0, 8'h55, 8'h00, 0, 0};
    vecs[27] = '{0, 1, 0, 8'h00, 8'h55, 0, 1};
    vecs[28] = '{0, 0, 0, 8'h00, 8'h00, 0, 1};

    do_reset();

    for (int i = 0; i < 29; i++) begin
      step(1'b1, 1'b0, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
      check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
    end

    // Fill, drop when full, drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'h10 + 8'(i));
    check("fill_full", 32'(full), 32'd1);
    wr(1'b0, 8'hFF);
    check("fill_drop_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rd();
      check($sformatf("fill_rd%0d", i), 32'(data_out), 32'(8'h10 + 8'(i)));
    end
    check("fill_drained", 32'(empty), 32'd1);

    // Full with simultaneous read and write: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'h20 + 8'(i));
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
    check("fullrw_dout", 32'(data_out), 32'h20);
    check("fullrw_full", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      rd();
      check($sformatf("fullrw_rd%0d", i), 32'(data_out), 32'(8'h20 + 8'(i)));
    end
    check("fullrw_empty", 32'(empty), 32'd1);

    // Wrap across index 15 -> 0.
    do_reset();
    for (int i = 0; i < 12; i++) wr(1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      rd();
      check($sformatf("wrap_a_rd%0d", i), 32'(data_out), 32'(8'h40 + 8'(i)));
    end
    for (int i = 0; i < 10; i++) wr(1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      rd();
      check($sformatf("wrap_b_rd%0d", i), 32'(data_out), 32'(8'h80 + 8'(i)));
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Soft reset mid-packet with concurrent strobes; packet count must be cleared.
    do_reset();
    wr(1'b1, 8'h08);
    wr(1'b0, 8'hB1);
    wr(1'b0, 8'hB2);
    rd();
    check("sr_hdr", 32'(data_out), 32'h08);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hDD);
    check("sr_empty", 32'(empty), 32'd1);
    check("sr_dout", 32'(data_out), 32'h00);
    rd();
    check("sr_empty_rd", 32'(data_out), 32'h00);
    wr(1'b0, 8'hC3);
    rd();
    check("sr_after_rd", 32'(data_out), 32'hC3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("sr_cnt_cleared", 32'(data_out), 32'h00);

    // Randomized run with write-heavy, read-heavy and balanced phases.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int   ph;
      logic we;
      logic re;
      ph = (i / 100) % 3;
      we = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2)
                     : ($urandom_range(0, 1) == 1);
      re = (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 8)
                     : ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0), we, re,
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
